next_pc_logic: RTL and testbench
================================

// Module: next_pc_logic
// PURPOSE
//   Next-program-counter selector for the fetch stage. Each rising clock edge it
//   registers the PC for the next fetch: the reset vector on restart, the branch
//   target when branch is asserted, otherwise pc_in + 1. It sits between the
//   PC register/fetch and the branch-resolution logic.
//   Output out feeds the instruction-memory address and returns as pc_in.
// PARAMETERS
//   PC_W       16       width of pc_in, target and out
//   RESET_PC   16'h0000 value loaded into out on restart
//   PC_INC     1        increment applied on sequential flow (words, not bytes)
// PORTS
//   clock    in   1     single system clock; all state updates on its rising edge
//   restart  in   1     reset: synchronous, active-high; also the pipeline restart
//   branch   in   1     1 = take target this cycle
//   target   in   PC_W  branch destination address
//   pc_in    in   PC_W  current PC (normally out fed back)
//   out      out  PC_W  registered next PC
// BEHAVIOUR
//   - Reset: synchronous, active-high. While restart=1 at a rising edge,
//     out <= RESET_PC, regardless of branch/target/pc_in.
//   - Priority at each rising edge: restart > branch > sequential.
//       restart=1             -> out <= RESET_PC
//       restart=0, branch=1   -> out <= target
//       restart=0, branch=0   -> out <= pc_in + PC_INC
//   - Latency: one cycle. out changes only on a rising edge and holds the value
//     between edges. No combinational path from inputs to out.
//   - Arithmetic: unsigned, PC_W bits, modulo 2^PC_W. The carry is discarded,
//     so 16'hFFFF + 1 wraps to 16'h0000. target is used verbatim;
//     it is not an offset and gets no sign extension.
//   - Inputs are sampled at the edge only; glitches between edges have no effect.
//   - Power-up value of out is undefined until the first edge with restart=1.
//     Synthesis init/X-propagation is not relied upon.
//   - restart held for several cycles: out stays at RESET_PC.
//     The first edge after restart deasserts applies the normal branch/sequential rule.
//   - branch=1 with target==pc_in is legal and holds the PC (self-loop).
//   - No handshake and no stall input. The caller gates branch and holds pc_in
//     if it needs to freeze fetch.
// STRUCTURE
//   - Shared package (cpu_pkg): PC_W, RESET_PC, PC_INC and a pc_t typedef
//     (logic [PC_W-1:0]) used by fetch, branch unit and this block.
//   - Internals: combinational next-value mux (priority encoded), then one
//     PC_W-bit register with synchronous restart.
//   - A single sub-module pc_incrementer (pc_in -> pc_in + PC_INC, wrap) is
//     natural; all else stays inline.
// TESTING
//   1. restart=1, branch=1, target=10, pc_in=5, one edge -> out=0x0000.
//      Restart overrides branch.
//   2. restart=0, branch=1, target=10, pc_in=0 -> out=10 after the next edge.
//   3. restart=0, branch=0, pc_in=10 -> out=11 after the edge; unchanged before it.
//   4. restart=0, branch=1, target=8, pc_in=11 -> out=8.
//      Then branch=0, pc_in=8 -> out=9.
//   5. restart=0, branch=0, pc_in=16'hFFFF -> out=16'h0000 (wrap).
//   6. restart=1 held 3 edges with branch toggling 0/1 -> out=0x0000 each edge.
//      Release with branch=0, pc_in=0 -> out=1.
//   Checks: compare out one edge after stimulus against the reference model
//   (priority mux + wrap). Assert out never changes except at a rising clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants.
// Used by fetch, the branch unit and the next-PC selector.
package cpu_pkg;
  localparam int PC_W = 16;
  typedef logic [PC_W-1:0] pc_t;
  localparam pc_t RESET_PC = 16'h0000;
  // Word-addressed: sequential flow steps by one instruction.
  localparam pc_t PC_INC = 16'h0001;
endpackage

// File: rtl/next_pc_logic_if.sv
// Branch/PC bundle between fetch, the branch unit and the
// next-PC selector.
interface next_pc_logic_if;
  import cpu_pkg::*;
  logic branch;
  pc_t  target;
  pc_t  pc_in;
  pc_t  out;

  modport master (
    output branch,
    output target,
    output pc_in,
    input  out
  );

  modport slave (
    input  branch,
    input  target,
    input  pc_in,
    output out
  );
endinterface

// File: rtl/pc_incrementer.sv
// Sequential-flow PC step.
// Modulo 2^PC_W: the carry out is dropped.
module pc_incrementer
  import cpu_pkg::*;
(
  input  pc_t i_pc,
  output pc_t o_pc
);
  assign o_pc = i_pc + PC_INC;
endmodule

// File: rtl/next_pc_logic.sv
// Next-PC register for fetch.
// Restart beats branch, branch beats sequential.
module next_pc_logic
  import cpu_pkg::*;
(
  input  logic           clock,
  input  logic           restart,
  next_pc_logic_if.slave bus
);
  pc_t w_inc;
  pc_t w_next;
  pc_t r_pc;

  pc_incrementer u_inc (
    .i_pc (bus.pc_in),
    .o_pc (w_inc)
  );

  // target is an absolute address, not an offset.
  always_comb begin
    w_next = w_inc;
    priority case (1'b1)
      bus.branch: w_next = bus.target;
      default:    w_next = w_inc;
    endcase
  end

  always_ff @(posedge clock) begin
    if (restart) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next;
    end
  end

  assign bus.out = r_pc;
endmodule

// File: tb/tb_next_pc_logic.sv
// Directed bench for next_pc_logic.
// Drives on the falling edge, checks 1ns after the rising edge.
module tb_next_pc_logic;
  import cpu_pkg::*;

  logic clock;
  logic restart;
  int   checks;
  int   failures;
  time  t_edge;

  next_pc_logic_if bus ();

  next_pc_logic dut (
    .clock   (clock),
    .restart (restart),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) t_edge = $time;

  // out may only move in the time step of a rising edge.
  always @(bus.out) begin
    checks++;
    assert ($time == t_edge) else begin
      failures++;
      $error("FAIL edge_only got_t=%0t exp_t=%0t", $time, t_edge);
    end
  end

  task automatic check(input string tag, input pc_t exp);
    checks++;
    assert (bus.out === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, bus.out, exp);
    end
  endtask

  task automatic step(
    input string tag,
    input logic  r,
    input logic  b,
    input pc_t   t,
    input pc_t   p,
    input pc_t   exp
  );
    @(negedge clock);
    restart    = r;
    bus.branch = b;
    bus.target = t;
    bus.pc_in  = p;
    @(posedge clock);
    #1;
    check(tag, exp);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    t_edge     = 0;
    restart    = 1'b1;
    bus.branch = 1'b0;
    bus.target = '0;
    bus.pc_in  = '0;

    step("rst_over_br", 1'b1, 1'b1, 16'd10, 16'd5, 16'h0000);
    step("branch_10", 1'b0, 1'b1, 16'd10, 16'd0, 16'd10);

    // Output must hold before the edge.
    @(negedge clock);
    bus.branch = 1'b0;
    bus.pc_in  = 16'd10;
    #2;
    check("hold_pre_edge", 16'd10);
    // Mid-cycle glitch on branch/target must be ignored.
    bus.branch = 1'b1;
    bus.target = 16'h0BAD;
    #1;
    bus.branch = 1'b0;
    #1;
    check("hold_glitch", 16'd10);
    @(posedge clock);
    #1;
    check("seq_11", 16'd11);

    step("branch_8", 1'b0, 1'b1, 16'd8, 16'd11, 16'd8);
    step("seq_9", 1'b0, 1'b0, 16'd0, 16'd8, 16'd9);
    step("wrap", 1'b0, 1'b0, 16'd0, 16'hFFFF, 16'h0000);
    step("seq_mid", 1'b0, 1'b0, 16'h1234, 16'h7FFF, 16'h8000);
    step("self_loop", 1'b0, 1'b1, 16'h1234, 16'h1234, 16'h1234);
    step("br_high", 1'b0, 1'b1, 16'hFFFE, 16'h0003, 16'hFFFE);

    step("rst_hold0", 1'b1, 1'b0, 16'h00AA, 16'h0050, 16'h0000);
    step("rst_hold1", 1'b1, 1'b1, 16'h00AA, 16'h0050, 16'h0000);
    step("rst_hold2", 1'b1, 1'b0, 16'h00AA, 16'h0050, 16'h0000);
    step("rst_release", 1'b0, 1'b0, 16'h00AA, 16'h0000, 16'h0001);
    step("seq_after", 1'b0, 1'b0, 16'h00AA, 16'h0001, 16'h0002);

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
